pdm_tx_modulator: RTL and testbench
===================================

Name: pdm_tx_modulator

Overview:
- Transmit-side counterpart of the microphone PDM decoder: converts a stream of signed 16-bit PCM samples into a 1-bit pulse-density bitstream for the board's audio-out low-pass filter.
- Samples are buffered in a small FIFO behind a valid/ready handshake; a first-order sigma-delta modulator emits one PDM bit per bit tick.
- Sits between the PCM sample source (loopback of data_mic, tone generator or FFT path) and the pdm_data_o / pdm_en_o board pins.

Parameters:
- CLK_DIV, 100, clk_i cycles per PDM bit (100 MHz / 100 = 1 MHz bit rate); legal range >= 2.
- OSR, 20, PDM bits per PCM sample (PCM rate = clk / (CLK_DIV*OSR)); legal range >= 1.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.

Ports:
- clk_i  in  1  system clock, 100 MHz.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  modulator enable.
- data_i  in  16  signed two's-complement PCM sample.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO can accept; equals !full.
- pdm_data_o  out  1  registered PDM bit.
- pdm_en_o  out  1  audio amplifier enable; high only in RUN.
- underrun_o  out  1  one-cycle pulse when a sample pop finds the FIFO empty.
- fifo_level_o  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, fifo_level_o=0, ready_o=1, pdm_data_o=0, pdm_en_o=0, underrun_o=0, accumulator=0, bit counter=0, hold counter=0, current sample=0x0000, state=IDLE.
- Push: occurs in any state when valid_i && ready_o. ready_o is combinational from the registered level (level < depth).
- Push into a full FIFO is impossible by the handshake. A same-cycle pop does not raise ready_o within that cycle.
- Bit tick: the bit counter runs 0..CLK_DIV-1 in RUN only. tick=1 on the cycle where count==CLK_DIV-1, after which the count wraps to 0. The counter is held at 0 in IDLE.
- Modulator, on each tick in RUN:
  - u = current_sample XOR 0x8000 (offset binary).
  - acc17 = {0,acc[15:0]} + u.
  - acc <= acc17[15:0].
  - pdm_data_o <= acc17[16], so the output changes on the cycle after the tick. Ones density = u/65536.
- Hold counter: increments on each tick and wraps at OSR-1.
  - On a tick with hold==OSR-1, pop the FIFO head into current_sample; it is used from the next tick on.
  - If the FIFO is empty at that pop: current_sample <= 0x0000 (midscale), underrun_o=1 for exactly that cycle, level stays 0.
- Same-cycle push and pop:
  - Level unchanged.
  - Empty FIFO: the pop underruns, the pushed sample is stored, level becomes 1.
- States:
  - IDLE: pdm_en_o=0, pdm_data_o=0, accumulator/counters held at 0. Go to RUN when en_i=1 and level>0; that transition pops the head into current_sample (the first tick uses it).
  - RUN: pdm_en_o=1 (registered, asserted the cycle after entry). Go to IDLE the cycle after en_i=0: pdm_en_o, pdm_data_o, acc and counters clear. FIFO contents are retained.
- Starvation does not leave RUN; the output plays midscale (alternating 0,1 from acc=0).
- Reset mid-operation: immediate return to reset values; FIFO contents are discarded.
- fifo_level_o updates the cycle after a push or pop.

Test Plan:
- Reset/idle:
  - Assert rst_ni=0 mid-RUN → all outputs reach reset values asynchronously, level=0, ready_o=1.
  - Push 3 samples with en_i=0 → level=3, pdm_en_o=0, pdm_data_o stays 0.
- Midscale:
  - Push 0x0000, en_i=1, CLK_DIV=4, OSR=4 → pdm_en_o=1 next cycle.
  - pdm_data_o sequence per tick 0,1,0,1.
  - underrun_o pulses at the 4th tick (FIFO empty), then output continues alternating.
- Extremes:
  - Push 0x8000 → all ticks output 0.
  - Push 0x7FFF → first tick 0, next 15 ticks 1 (acc FFFF, FFFE, ...).
  - Push 0x4000 (u=0xC000) → pattern 0,1,1,1 repeating.
- Full/backpressure:
  - Hold valid_i=1 with en_i=0 → 16 samples accepted, level=16, ready_o=0; a 17th value is not taken.
  - Enable → first pop happens on entry to RUN, level=15, ready_o=1 next cycle, one more push accepted.
- Simultaneous push/pop on empty:
  - Push exactly on the hold==OSR-1 tick with level=0 → underrun_o=1 that cycle, level=1 afterwards, that sample popped at the next sample boundary.
- Disable mid-stream:
  - Drop en_i with 5 samples queued → next cycle pdm_en_o=0, pdm_data_o=0, level stays 5.
  - Re-enable → a pop on entry gives level=4; the accumulator restarts from 0.

Source files
------------

// File: rtl/pdm_tx_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pdm_tx_modulator
// Brief    : PCM sample FIFO feeding a first-order sigma-delta modulator that
//            drives a 1-bit PDM audio output.
// Revision : 1.0
// ============================================================================
module pdm_tx_modulator #(
    parameter int CLK_DIV = 100,
    parameter int OSR     = 20,
    parameter int FIFO_AW = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [15:0]        data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               pdm_data_o,
    output logic               pdm_en_o,
    output logic               underrun_o,
    output logic [FIFO_AW:0]   fifo_level_o
);

    localparam int c_DEPTH  = 2 ** FIFO_AW;
    localparam int c_CNT_W  = $clog2(CLK_DIV);
    localparam int c_HOLD_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(OSR - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [FIFO_AW:0]    c_LVL_FULL  = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW:0]    c_LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]  c_PTR_ONE   = FIFO_AW'(1);
    localparam logic [15:0]         c_SIGN_FLIP = 16'h8000;
    localparam logic [15:0]         c_MIDSCALE  = 16'h0000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [15:0]          r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_level;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [15:0]          r_acc;
    logic [15:0]          r_sample;
    logic                 r_pdm_data;
    logic                 r_pdm_en;

    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_pop;
    logic                 w_underrun;
    logic [15:0]          w_head;
    logic [16:0]          w_acc17;

    assign w_fifo_empty = (r_level == '0);
    assign ready_o      = (r_level < c_LVL_FULL);
    assign w_push       = valid_i && ready_o;
    assign w_head       = r_mem[r_rd_ptr];

    // Offset-binary conversion turns the signed sample into a ones density
    // where 0x8000 (most negative) is silence-low and 0x7FFF is nearly all ones.
    assign w_acc17 = {1'b0, r_acc} + {1'b0, r_sample ^ c_SIGN_FLIP};

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        w_tick       = 1'b0;
        w_boundary   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_i && !w_fifo_empty) begin
                    w_state_next = S_RUN;
                    w_start      = 1'b1;
                end
            end
            S_RUN: begin
                if (!en_i) begin
                    w_state_next = S_IDLE;
                    w_stop       = 1'b1;
                end else begin
                    w_tick     = (r_cnt == c_CNT_MAX);
                    w_boundary = w_tick && (r_hold == c_HOLD_MAX);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A pop request on an empty FIFO is an underrun; a push in the same cycle
    // is still stored because the pop is suppressed rather than forwarded.
    assign w_pop      = (w_start || w_boundary) && !w_fifo_empty;
    assign w_underrun = w_boundary && w_fifo_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_hold     <= '0;
            r_acc      <= '0;
            r_sample   <= c_MIDSCALE;
            r_pdm_data <= 1'b0;
            r_pdm_en   <= 1'b0;
        end else if (w_start) begin
            r_cnt      <= '0;
            r_hold     <= '0;
            r_acc      <= '0;
            r_sample   <= w_head;
            r_pdm_data <= 1'b0;
            r_pdm_en   <= 1'b1;
        end else if (w_stop || (r_state == S_IDLE)) begin
            r_cnt      <= '0;
            r_hold     <= '0;
            r_acc      <= '0;
            r_pdm_data <= 1'b0;
            r_pdm_en   <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : (r_cnt + c_CNT_ONE);
            if (w_tick) begin
                r_acc      <= w_acc17[15:0];
                r_pdm_data <= w_acc17[16];
                r_hold     <= (r_hold == c_HOLD_MAX) ? '0 : (r_hold + c_HOLD_ONE);
            end
            // Starvation keeps the modulator running on midscale.
            if (w_boundary) begin
                r_sample <= w_pop ? w_head : c_MIDSCALE;
            end
        end
    end

    assign pdm_data_o   = r_pdm_data;
    assign pdm_en_o     = r_pdm_en;
    assign underrun_o   = w_underrun;
    assign fifo_level_o = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pdm_tx_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pdm_tx_modulator
// Brief    : Directed bench with a cumulative-sum reference model and
//            literal per-tick expectations for pdm_tx_modulator.
// Revision : 1.0
// ============================================================================
module tb_pdm_tx_modulator;

    localparam int CLK_DIV = 4;
    localparam int OSR     = 4;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 2 ** FIFO_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_i = 1'b0;
    logic [15:0]       data_i = 16'h0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic              pdm_data_o;
    logic              pdm_en_o;
    logic              underrun_o;
    logic [FIFO_AW:0]  fifo_level_o;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    pdm_tx_modulator #(
        .CLK_DIV (CLK_DIV),
        .OSR     (OSR),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pdm_data_o   (pdm_data_o),
        .pdm_en_o     (pdm_en_o),
        .underrun_o   (underrun_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the modulator output is the carry of a running sum of
    // offset-binary samples, i.e. bit n = floor(S_n/65536) - floor(S_(n-1)/65536).
    logic [15:0] m_q [$];
    bit          m_run = 1'b0;
    int          m_k = 0;
    longint      m_sum = 0;
    logic [15:0] m_sample = 16'h0;
    bit          m_pdm = 1'b0;
    bit          m_en = 1'b0;

    function automatic bit m_is_tick(input int k);
        return ((k + 1) % CLK_DIV) == 0;
    endfunction

    function automatic bit m_is_boundary(input int k);
        return m_is_tick(k) && ((((k + 1) / CLK_DIV) % OSR) == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit     push;
        longint prev;
        if (!rst_n) begin
            m_q.delete();
            m_run = 1'b0; m_k = 0; m_sum = 0;
            m_sample = 16'h0; m_pdm = 1'b0; m_en = 1'b0;
        end else begin
            push = valid_i && (m_q.size() < DEPTH);
            if (!m_run) begin
                if (en_i && m_q.size() > 0) begin
                    m_sample = m_q.pop_front();
                    m_run = 1'b1; m_k = 0; m_sum = 0; m_en = 1'b1; m_pdm = 1'b0;
                end
            end else if (!en_i) begin
                m_run = 1'b0; m_en = 1'b0; m_pdm = 1'b0;
            end else begin
                if (m_is_tick(m_k)) begin
                    prev  = m_sum;
                    m_sum = m_sum + longint'({48'h0, m_sample ^ 16'h8000});
                    m_pdm = ((m_sum / 65536) != (prev / 65536));
                    if (m_is_boundary(m_k)) begin
                        m_sample = (m_q.size() > 0) ? m_q.pop_front() : 16'h0000;
                    end
                end
                m_k++;
            end
            if (push) m_q.push_back(data_i);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready_o", 32'(ready_o), 32'(m_q.size() < DEPTH));
            check("fifo_level_o", 32'(fifo_level_o), 32'(m_q.size()));
            check("pdm_data_o", 32'(pdm_data_o), 32'(m_pdm));
            check("pdm_en_o", 32'(pdm_en_o), 32'(m_en));
            check("underrun_o", 32'(underrun_o),
                  32'(m_run && en_i && m_is_boundary(m_k) && (m_q.size() == 0)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input logic [15:0] v);
        valid_i = 1'b1;
        data_i  = v;
        step();
        valid_i = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Records the PDM bit after each of n ticks and the underrun flag seen
    // during each tick cycle; call right after the cycle that entered RUN.
    task automatic run_ticks(input int n, output logic [31:0] bits, output logic [31:0] urs);
        bits = '0;
        urs  = '0;
        for (int i = 0; i < n; i++) begin
            repeat (CLK_DIV - 1) step();
            urs[i] = underrun_o;
            step();
            bits[i] = pdm_data_o;
        end
    endtask

    initial begin
        logic [31:0] bits;
        logic [31:0] urs;

        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        started = 1'b1;
        check("rst level", 32'(fifo_level_o), 32'd0);
        check("rst ready", 32'(ready_o), 32'd1);
        check("rst pdm_en", 32'(pdm_en_o), 32'd0);
        check("rst pdm_data", 32'(pdm_data_o), 32'd0);

        // Queue while disabled
        push_one(16'h1234); push_one(16'h5678); push_one(16'h9ABC);
        step();
        check("idle level3", 32'(fifo_level_o), 32'd3);
        check("idle pdm_en", 32'(pdm_en_o), 32'd0);
        check("idle pdm_data", 32'(pdm_data_o), 32'd0);

        // Async reset in the middle of RUN
        en_i = 1'b1;
        step();
        check("run entry en", 32'(pdm_en_o), 32'd1);
        repeat (6) step();
        #1 rst_n = 1'b0;
        #1;
        check("async rst pdm_en", 32'(pdm_en_o), 32'd0);
        check("async rst level", 32'(fifo_level_o), 32'd0);
        check("async rst ready", 32'(ready_o), 32'd1);
        check("async rst pdm_data", 32'(pdm_data_o), 32'd0);
        en_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Midscale: alternating output, underrun at the 4th tick
        push_one(16'h0000);
        en_i = 1'b1;
        step();
        check("mid pdm_en", 32'(pdm_en_o), 32'd1);
        run_ticks(6, bits, urs);
        check("mid bits", bits, 32'h2A);
        check("mid underrun", urs, 32'h08);
        en_i = 1'b0;
        step();

        // Most negative sample: all zeros
        push_one(16'h8000);
        en_i = 1'b1;
        step();
        run_ticks(4, bits, urs);
        check("neg bits", bits, 32'h0);
        check("neg underrun", urs, 32'h08);
        en_i = 1'b0;
        step();

        // Most positive sample held for 16 ticks
        repeat (4) push_one(16'h7FFF);
        en_i = 1'b1;
        step();
        run_ticks(16, bits, urs);
        check("pos bits", bits, 32'hFFFE);
        check("pos underrun", urs, 32'h8000);
        en_i = 1'b0;
        step();

        // Quarter-positive sample: 0,1,1,1 repeating
        repeat (2) push_one(16'h4000);
        en_i = 1'b1;
        step();
        run_ticks(8, bits, urs);
        check("q bits", bits, 32'hEE);
        check("q underrun", urs, 32'h80);
        en_i = 1'b0;
        step();

        // Fill to full with backpressure
        valid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data_i = 16'(16'h1000 + i);
            step();
        end
        valid_i = 1'b0;
        check("full level", 32'(fifo_level_o), 32'd16);
        check("full ready", 32'(ready_o), 32'd0);
        en_i = 1'b1;
        step();
        check("full pop level", 32'(fifo_level_o), 32'd15);
        check("full pop ready", 32'(ready_o), 32'd1);
        push_one(16'hBEEF);
        check("refill level", 32'(fifo_level_o), 32'd16);
        check("refill ready", 32'(ready_o), 32'd0);
        en_i = 1'b0;
        step();
        reset_pulse();
        step();

        // Push coinciding with an empty-FIFO sample boundary
        push_one(16'h1111);
        en_i = 1'b1;
        step();
        repeat (15) step();
        valid_i = 1'b1;
        data_i  = 16'h2222;
        #1;
        check("sim underrun", 32'(underrun_o), 32'd1);
        #1;
        step();
        valid_i = 1'b0;
        check("sim level1", 32'(fifo_level_o), 32'd1);
        check("sim underrun gone", 32'(underrun_o), 32'd0);
        repeat (15) step();
        check("sim next boundary", 32'(underrun_o), 32'd0);
        step();
        check("sim popped", 32'(fifo_level_o), 32'd0);
        en_i = 1'b0;
        step();

        // Disable mid-stream, then restart from a cleared accumulator
        repeat (6) push_one(16'h4000);
        en_i = 1'b1;
        step();
        check("dis entry level", 32'(fifo_level_o), 32'd5);
        repeat (9) step();
        en_i = 1'b0;
        step();
        check("dis pdm_en", 32'(pdm_en_o), 32'd0);
        check("dis pdm_data", 32'(pdm_data_o), 32'd0);
        check("dis level", 32'(fifo_level_o), 32'd5);
        en_i = 1'b1;
        step();
        check("reen level", 32'(fifo_level_o), 32'd4);
        check("reen pdm_en", 32'(pdm_en_o), 32'd1);
        run_ticks(2, bits, urs);
        check("reen bits", bits, 32'h2);
        en_i = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
